ps2_keyboard: RTL and testbench

PS/2 keyboard front end for the Mango One. It receives device-to-host PS/2 frames and decodes scan-code set 2 into ASCII. It presents the result as the Apple-I style keyboard register that `apple1_top` reads at $D010/$D011. It drives `apple1_top`'s `keycode` input and consumes its `keystrobe` output. It is the input-side counterpart of the terminal output path.

---
 rtl/ps2_keyboard_pkg.sv | 24 ++
 rtl/ps2_keyboard_scan_to_ascii.sv | 66 ++++++
 rtl/ps2_keyboard.sv | 146 ++++++++++++++
 tb/tb_ps2_keyboard.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_keyboard_pkg.sv
// Shared constants for the PS/2 keyboard front end: scan-code set 2 values,
// ASCII codes and the frame receiver state encoding.
package ps2_keyboard_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_ESC    = 8'h76;

    localparam logic [6:0] ASCII_CR     = 7'h0D;
    localparam logic [6:0] ASCII_RUBOUT = 7'h5F;
    localparam logic [6:0] ASCII_ESC    = 7'h1B;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_STOP  = 2'd2
    } frame_state_t;

endpackage

// File: rtl/ps2_keyboard_scan_to_ascii.sv
// Combinational scan-code set 2 to ASCII map, US layout. Letters come out
// lowercase and are folded to uppercase when shift XOR caps.
module ps2_scan_to_ascii
    import ps2_keyboard_pkg::*;
(
    input  logic [7:0] scan,
    input  logic       shift,
    input  logic       caps,
    output logic [6:0] ascii,
    output logic       mapped
);

    logic [6:0] base;
    logic       letter;

    always_comb begin
        base   = '0;
        letter = 1'b1;
        mapped = 1'b1;
        unique case (scan)
            8'h1C: base = 7'h61;  8'h32: base = 7'h62;  8'h21: base = 7'h63;
            8'h23: base = 7'h64;  8'h24: base = 7'h65;  8'h2B: base = 7'h66;
            8'h34: base = 7'h67;  8'h33: base = 7'h68;  8'h43: base = 7'h69;
            8'h3B: base = 7'h6A;  8'h42: base = 7'h6B;  8'h4B: base = 7'h6C;
            8'h3A: base = 7'h6D;  8'h31: base = 7'h6E;  8'h44: base = 7'h6F;
            8'h4D: base = 7'h70;  8'h15: base = 7'h71;  8'h2D: base = 7'h72;
            8'h1B: base = 7'h73;  8'h2C: base = 7'h74;  8'h3C: base = 7'h75;
            8'h2A: base = 7'h76;  8'h1D: base = 7'h77;  8'h22: base = 7'h78;
            8'h35: base = 7'h79;  8'h1A: base = 7'h7A;
            default: letter = 1'b0;
        endcase
        if (!letter) begin
            unique case (scan)
                8'h0E: base = shift ? 7'h7E : 7'h60;
                8'h16: base = shift ? 7'h21 : 7'h31;
                8'h1E: base = shift ? 7'h40 : 7'h32;
                8'h26: base = shift ? 7'h23 : 7'h33;
                8'h25: base = shift ? 7'h24 : 7'h34;
                8'h2E: base = shift ? 7'h25 : 7'h35;
                8'h36: base = shift ? 7'h5E : 7'h36;
                8'h3D: base = shift ? 7'h26 : 7'h37;
                8'h3E: base = shift ? 7'h2A : 7'h38;
                8'h46: base = shift ? 7'h28 : 7'h39;
                8'h45: base = shift ? 7'h29 : 7'h30;
                8'h4E: base = shift ? 7'h5F : 7'h2D;
                8'h55: base = shift ? 7'h2B : 7'h3D;
                8'h54: base = shift ? 7'h7B : 7'h5B;
                8'h5B: base = shift ? 7'h7D : 7'h5D;
                8'h5D: base = shift ? 7'h7C : 7'h5C;
                8'h4C: base = shift ? 7'h3A : 7'h3B;
                8'h52: base = shift ? 7'h22 : 7'h27;
                8'h41: base = shift ? 7'h3C : 7'h2C;
                8'h49: base = shift ? 7'h3E : 7'h2E;
                8'h4A: base = shift ? 7'h3F : 7'h2F;
                8'h29: base = 7'h20;
                SC_ENTER: base = ASCII_CR;
                SC_BKSP:  base = ASCII_RUBOUT;
                SC_ESC:   base = ASCII_ESC;
                default:  mapped = 1'b0;
            endcase
        end
        // Clearing bit 5 turns a lowercase letter into its capital.
        ascii = (letter && (shift ^ caps)) ? (base & 7'h5F) : base;
    end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 device-to-host frame receiver, set-2 decoder and Apple-I style key
// latch ($D010/$D011): bit 7 = key available, bits 6:0 = ASCII.
module ps2_keyboard
    import ps2_keyboard_pkg::*;
#(
    parameter int TIMEOUT = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       keystrobe,
    output logic [7:0] keycode,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT + 1) + 1;

    logic [1:0]   clk_sync, dat_sync;
    logic         clk_prev, fall, din;
    frame_state_t state, state_nx;
    logic [3:0]   bit_cnt;
    logic [8:0]   shreg;
    logic [TW-1:0] idle_cnt;
    logic         good, bad, byte_valid;
    logic         brk, ext, shift_l, shift_r, caps;
    logic [6:0]   map_ascii, key_char;
    logic         map_hit, key_load;
    logic [7:0]   rx_byte;

    assign fall    = clk_prev & ~clk_sync[1];
    assign din     = dat_sync[1];
    assign rx_byte = shreg[7:0];

    // Sync flops reset to the idle-high bus level so release gives no false edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
            clk_prev <= clk_sync[1];
        end
    end

    always_comb begin
        state_nx = state;
        good     = 1'b0;
        bad      = 1'b0;
        unique case (state)
            ST_IDLE:  if (fall && !din) state_nx = ST_SHIFT;
            ST_SHIFT: if (fall && bit_cnt == 4'd8) state_nx = ST_STOP;
            ST_STOP: begin
                if (fall) begin
                    state_nx = ST_IDLE;
                    if (din && (^shreg)) good = 1'b1;
                    else                 bad  = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        if (state != ST_IDLE && !fall && idle_cnt >= TW'(TIMEOUT)) begin
            state_nx = ST_IDLE;
            bad      = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            idle_cnt   <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nx;
            byte_valid <= good;
            frame_err  <= bad;
            if (fall || state_nx == ST_IDLE) idle_cnt <= '0;
            else                             idle_cnt <= idle_cnt + 1'b1;
            if (state == ST_IDLE) begin
                bit_cnt <= '0;
            end else if (state == ST_SHIFT && fall) begin
                shreg   <= {din, shreg[8:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    ps2_scan_to_ascii u_map (
        .scan   (rx_byte),
        .shift  (shift_l | shift_r),
        .caps   (caps),
        .ascii  (map_ascii),
        .mapped (map_hit)
    );

    // Only non-prefix make codes produce keys; extended codes only for keypad Enter.
    always_comb begin
        key_load = 1'b0;
        key_char = map_ascii;
        if (byte_valid && rx_byte != SC_BREAK && rx_byte != SC_EXT && !brk) begin
            if (ext) begin
                if (rx_byte == SC_ENTER) begin
                    key_load = 1'b1;
                    key_char = ASCII_CR;
                end
            end else begin
                key_load = map_hit;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            brk     <= 1'b0;
            ext     <= 1'b0;
            shift_l <= 1'b0;
            shift_r <= 1'b0;
            caps    <= 1'b0;
            keycode <= '0;
        end else begin
            if (byte_valid) begin
                if (rx_byte == SC_BREAK) begin
                    brk <= 1'b1;
                end else if (rx_byte == SC_EXT) begin
                    ext <= 1'b1;
                end else begin
                    brk <= 1'b0;
                    ext <= 1'b0;
                    if (!ext) begin
                        if (rx_byte == SC_LSHIFT) shift_l <= !brk;
                        if (rx_byte == SC_RSHIFT) shift_r <= !brk;
                        if (rx_byte == SC_CAPS && !brk) caps <= !caps;
                    end
                end
            end
            if (key_load)       keycode <= {1'b1, key_char};
            else if (keystrobe) keycode[7] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_keyboard.sv
module tb_ps2_keyboard;

    localparam int TIMEOUT = 2000;

    logic       clk = 1'b0;
    logic       reset, ps2_clk, ps2_data, keystrobe;
    logic [7:0] keycode;
    logic       frame_err;

    always #5 clk = ~clk;

    ps2_keyboard #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .keystrobe(keystrobe), .keycode(keycode), .frame_err(frame_err)
    );

    typedef struct packed { logic is_err; logic [7:0] val; } exp_t;
    exp_t q[$];
    int n_vec = 0, n_bad = 0;

    bit m_brk, m_ext, m_shl, m_shr, m_caps;
    logic [7:0] m_kc = 8'h00;
    logic [7:0] mon_last = 8'h00;

    byte unsigned lcode[26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
                                8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,
                                8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
    byte unsigned pcode[21] = '{8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46,8'h45,
                                8'h4E,8'h55,8'h54,8'h5B,8'h5D,8'h4C,8'h52,8'h41,8'h49,8'h4A,8'h29};
    byte unsigned pun_lo[21] = '{8'h31,8'h32,8'h33,8'h34,8'h35,8'h36,8'h37,8'h38,8'h39,8'h30,
                                 8'h2D,8'h3D,8'h5B,8'h5D,8'h5C,8'h3B,8'h27,8'h2C,8'h2E,8'h2F,8'h20};
    byte unsigned pun_hi[21] = '{8'h21,8'h40,8'h23,8'h24,8'h25,8'h5E,8'h26,8'h2A,8'h28,8'h29,
                                 8'h5F,8'h2B,8'h7B,8'h7D,8'h7C,8'h3A,8'h22,8'h3C,8'h3E,8'h3F,8'h20};
    byte unsigned pool[24] = '{8'h1C,8'h32,8'h1A,8'h16,8'h45,8'h4E,8'h52,8'h4A,8'h29,8'h0E,
                               8'h12,8'h59,8'h58,8'hF0,8'hF0,8'hE0,8'h5A,8'h66,8'h76,8'hAA,
                               8'hFA,8'hEE,8'h75,8'h3C};

    function automatic int ascii_of(byte unsigned c, bit sh, bit cp);
        for (int i = 0; i < 26; i++)
            if (lcode[i] == c) return (sh ^ cp) ? ("A" + i) : ("a" + i);
        for (int i = 0; i < 21; i++)
            if (pcode[i] == c) return sh ? int'(pun_hi[i]) : int'(pun_lo[i]);
        case (c)
            8'h0E: return sh ? 'h7E : 'h60;
            8'h5A: return 'h0D;
            8'h66: return 'h5F;
            8'h76: return 'h1B;
            default: return -1;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    task automatic push_kc(input logic [7:0] v);
        if (v != m_kc) begin
            q.push_back('{1'b0, v});
            m_kc = v;
        end
    endtask

    task automatic model_byte(input byte unsigned b, output bit got);
        int a;
        got = 0;
        if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE0) m_ext = 1;
        else begin
            if (m_ext) begin
                if (!m_brk && b == 8'h5A) begin push_kc(8'h8D); got = 1; end
            end else if (b == 8'h12) m_shl = !m_brk;
            else if (b == 8'h59) m_shr = !m_brk;
            else if (b == 8'h58) begin if (!m_brk) m_caps = !m_caps; end
            else if (!m_brk) begin
                a = ascii_of(b, m_shl | m_shr, m_caps);
                if (a >= 0) begin push_kc({1'b1, 7'(a)}); got = 1; end
            end
            m_brk = 0;
            m_ext = 0;
        end
    endtask

    task automatic ps2_bit(input logic v);
        ps2_data = v;
        repeat (3) @(posedge clk); #1 ps2_clk = 1'b0;
        repeat (6) @(posedge clk); #1 ps2_clk = 1'b1;
        repeat (3) @(posedge clk); #1;
    endtask

    task automatic send_byte(input byte unsigned b, input bit bad = 0,
                             input bit stb = 0, input bit tchk = 0);
        logic [7:0] old;
        logic [7:0] bv;
        bit got;
        bv = b;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(bv[i]);
        ps2_bit(~(^bv) ^ bad);
        got = 0;
        if (bad) q.push_back('{1'b1, 8'h00});
        else model_byte(b, got);
        if (stb && !got && m_kc[7]) push_kc(m_kc & 8'h7F);
        ps2_data = 1'b1;
        repeat (3) @(posedge clk); #1 ps2_clk = 1'b0;
        old = keycode;
        repeat (3) @(posedge clk); #1;
        if (stb) keystrobe = 1'b1;
        if (tchk) begin
            chk("keycode_before_n3", keycode, old);
            chk("frame_err_at_n2", {7'd0, frame_err}, {7'd0, bad});
        end
        @(posedge clk); #1 keystrobe = 1'b0;
        if (tchk) chk("keycode_at_n3", keycode, m_kc);
        repeat (4) @(posedge clk); #1 ps2_clk = 1'b1;
        repeat (3) @(posedge clk); #1;
    endtask

    task automatic strobe();
        if (m_kc[7]) push_kc(m_kc & 8'h7F);
        keystrobe = 1'b1;
        @(posedge clk); #1 keystrobe = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic pop_chk(input bit is_err, input logic [7:0] v);
        exp_t e;
        n_vec++;
        if (q.size() == 0) begin
            n_bad++;
            $display("FAIL monitor_unexpected: got %s %h, expected nothing", is_err ? "frame_err" : "keycode", v);
        end else begin
            e = q.pop_front();
            if (e.is_err != is_err || (!is_err && e.val !== v)) begin
                n_bad++;
                $display("FAIL monitor_%s: got err=%0d kc=%h, expected err=%0d kc=%h",
                         is_err ? "frame_err" : "keycode", is_err, v, e.is_err, e.val);
            end
        end
    endtask

    always @(negedge clk) begin
        if (frame_err === 1'b1) pop_chk(1'b1, 8'h00);
        if (keycode !== mon_last) begin
            pop_chk(1'b0, keycode);
            mon_last = keycode;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        ps2_clk = 1'b1; ps2_data = 1'b1; keystrobe = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #20;
        chk("reset_keycode", keycode, 8'h00);
        chk("reset_frame_err", {7'd0, frame_err}, 8'h00);
        @(posedge clk); #1 reset = 1'b1;
        repeat (4) @(posedge clk); #1;

        send_byte(8'h1C, 0, 0, 1);
        chk("a_make", keycode, 8'hE1);
        send_byte(8'hF0); send_byte(8'h1C);
        chk("a_break", keycode, 8'hE1);

        send_byte(8'h12); send_byte(8'h1C);
        chk("shift_a", keycode, 8'hC1);
        strobe();
        chk("strobe_clear", keycode, 8'h41);
        send_byte(8'hF0); send_byte(8'h12); send_byte(8'h1C);
        chk("unshift_a", keycode, 8'hE1);

        send_byte(8'h58); send_byte(8'h16);
        chk("caps_digit", keycode, 8'hB1);
        send_byte(8'h1C);
        chk("caps_a", keycode, 8'hC1);
        send_byte(8'h12); send_byte(8'h1C);
        chk("caps_shift_a", keycode, 8'hE1);
        send_byte(8'hF0); send_byte(8'h12); send_byte(8'h58);

        send_byte(8'h1C, 1, 0, 1);
        chk("parity_keep", keycode, 8'hE1);
        q.push_back('{1'b1, 8'h00});
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)));
        repeat (TIMEOUT + 20) @(posedge clk); #1;
        send_byte(8'h5A);
        chk("enter_after_timeout", keycode, 8'h8D);

        strobe();
        send_byte(8'hE0); send_byte(8'h5A);
        chk("ext_enter", keycode, 8'h8D);
        send_byte(8'hE0); send_byte(8'h12); send_byte(8'h1C);
        chk("fake_shift", keycode, 8'hE1);
        send_byte(8'h66);
        chk("rubout", keycode, 8'hDF);
        send_byte(8'h29, 0, 1, 1);
        chk("strobe_vs_key", keycode, 8'hA0);

        send_byte(8'h12); send_byte(8'h1C);
        chk("pre_reset", keycode, 8'hC1);
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        push_kc(8'h00);
        m_brk = 0; m_ext = 0; m_shl = 0; m_shr = 0; m_caps = 0;
        reset = 1'b0;
        #1;
        chk("async_reset", keycode, 8'h00);
        repeat (3) @(posedge clk); #1 reset = 1'b1;
        repeat (4) @(posedge clk); #1;
        send_byte(8'h1C);
        chk("after_reset", keycode, 8'hE1);

        for (int n = 0; n < 70; n++) begin
            send_byte(pool[$urandom_range(0, 23)], ($urandom_range(0, 15) == 0),
                      ($urandom_range(0, 9) == 0), 1);
            if ($urandom_range(0, 7) == 0) strobe();
        end

        repeat (20) @(posedge clk); #1;
        n_vec++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
